multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle successor to the single-cycle opcode decoder. A Moore state machine sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It stalls on a memory ready handshake and flags illegal opcodes. It drives the same datapath control strobes as before, plus PC/IR write enables and a retired-instruction counter; it sits between the instruction register and the multi-cycle datapath.

## Interface
- OP_W, 6: opcode width; opcode values below are given at 6 bits and zero-extended to OP_W.
- ALUOP_W, 6: ALUOP width; must be ≥ OP_W.
- ALUOP_ADD, 6'b100000: ALU code issued for load/store address add.
- CNT_W, 16: retired-counter width.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  OP_W  opcode field from the instruction register.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write  out  1  PC update enable.
- ir_write  out  1  instruction-register load enable.
- RegDst, jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  datapath strobes.
- ALUOP  out  ALUOP_W  ALU operation select.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Opcode classes:
  - R = 000000.
  - IMM = 000110, 000111, 001000, 001001.
  - BR = 000011, 000100, 000101.
  - LW = 100011.
  - SW = 101011.
  - J = 000010.
  - Anything else is illegal.
- The opcode is latched into op_q at the DECODE cycle. Later states use op_q only.
- FETCH:
  - MemRead=1.
  - While mem_ready=0: hold in FETCH.
  - On mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE:
  - J: jump=1, pc_write=1, retire, go to FETCH.
  - Illegal: illegal=1, go to FETCH, no retire.
  - Otherwise go to EXEC.
- EXEC:
  - R: ALUOP = all ones, ALUSrc=0, go to WB.
  - IMM: ALUOP = op_q zero-extended, ALUSrc=1, go to WB.
  - BR: ALUOP = op_q, ALUSrc=0, Branch=1, pc_write=0, retire, go to FETCH. The datapath gates the PC with Branch and zero.
  - LW/SW: ALUOP = ALUOP_ADD, ALUSrc=1, go to MEM.
- MEM:
  - LW: MemRead=1.
  - SW: MemWrite=1.
  - Hold while mem_ready=0.
  - On mem_ready=1: LW goes to WB; SW retires and goes to FETCH.
- WB:
  - RegWrite=1.
  - R: RegDst=0.
  - IMM and LW: RegDst=1.
  - LW: MemtoReg=1.
  - Retire, go to FETCH.
- Strobe defaults: every strobe not listed for a state is 0. ALUOP = 0 outside EXEC.
- Retire increments retired by 1, wrapping modulo 2^CNT_W.
- Encodings 5–7 of state are unreachable; if entered, the next state is FETCH with all strobes 0.

## Timing
- Outputs are combinational from state and op_q. There is no same-cycle path from instruction to any strobe.
- instruction is sampled only on the DECODE clock edge.
- mem_ready is sampled only in FETCH and MEM; it is ignored elsewhere.
- Minimum cycles per instruction (mem_ready held high): J=2, BR=3, R=4, IMM=4, SW=4, LW=5. Each wait cycle adds 1.
- Reset asserted:
  - Immediately: state=FETCH, op_q=0, retired=0, all strobes and ALUOP=0, illegal=0.
  - Asynchronously, mid-MEM, MemWrite drops the same instant.
- After reset deassertion: FETCH strobes (MemRead=1) appear in the first cycle.
- Retire and reset in the same cycle: reset wins.

## Test plan
- Reset during SW MEM with mem_ready=0 -> MemWrite falls without a clock edge; state=0, retired=0.
- R-type 000000, mem_ready=1 -> states 0,1,2,4,0; ALUOP=6'b111111 in EXEC; RegWrite=1, RegDst=0 in WB; retired 0→1.
- LW 100011 with mem_ready low for 2 MEM cycles -> 7 cycles total; ALUOP=6'b100000 in EXEC; MemRead=1 for 3 MEM cycles; WB has MemtoReg=1, RegDst=1.
- BR 000100 -> 3 cycles; Branch=1 only in EXEC with ALUOP=6'b000100; RegWrite never 1.
- J 000010 then illegal 111111 -> J: jump=1, pc_write=1 in DECODE, 2 cycles. Illegal: illegal pulses 1 cycle in DECODE; retired increments only for J.
- CNT_W=2, five back-to-back J instructions -> retired sequence 1,2,3,0,1.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
//
// Bundles the instruction-side inputs and the datapath-side control outputs of
// the multi-cycle control unit. Clock and reset stay outside as plain ports.
//
//   master : the control unit (consumes instruction/mem_ready, drives strobes)
//   slave  : the datapath / environment (drives instruction/mem_ready)
//
// Signals
//   instruction  OP_W     opcode field from the instruction register
//   mem_ready    1        memory completes the current read/write this cycle
//   pc_write     1        PC update enable
//   ir_write     1        instruction-register load enable
//   RegDst .. RegWrite    datapath strobes
//   ALUOP        ALUOP_W  ALU operation select
//   illegal      1        one-cycle pulse on an unknown opcode
//   state        3        current FSM state (FETCH=0 .. WB=4)
//   retired      CNT_W    count of completed instructions
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 16
);
    logic [OP_W-1:0]    instruction;
    logic               mem_ready;
    logic               pc_write;
    logic               ir_write;
    logic               RegDst;
    logic               jump;
    logic               Branch;
    logic               MemRead;
    logic               MemtoReg;
    logic               MemWrite;
    logic               ALUSrc;
    logic               RegWrite;
    logic [ALUOP_W-1:0] ALUOP;
    logic               illegal;
    logic [2:0]         state;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  instruction, mem_ready,
        output pc_write, ir_write, RegDst, jump, Branch, MemRead, MemtoReg,
               MemWrite, ALUSrc, RegWrite, ALUOP, illegal, state, retired
    );

    modport slave (
        output instruction, mem_ready,
        input  pc_write, ir_write, RegDst, jump, Branch, MemRead, MemtoReg,
               MemWrite, ALUSrc, RegWrite, ALUOP, illegal, state, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style control FSM for a multi-cycle datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> MEM -> WB (skipping states it does not need),
// stalls in FETCH/MEM on the memory ready handshake, flags illegal opcodes and
// counts retired instructions.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   bus    master modport of multicycle_control_unit_if (see that file)
//
// The opcode is captured into op_q on the clock edge that enters DECODE (the
// same edge that loads the instruction register), so every strobe, including
// the DECODE-cycle jump/illegal outputs, is decoded from state and op_q only.
// ALUOP_W must be at least OP_W so opcodes fit ALUOP unchanged.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int                 OP_W      = 6,
    parameter int                 ALUOP_W   = 6,
    parameter logic [ALUOP_W-1:0] ALUOP_ADD = ALUOP_W'(6'b100000),
    parameter int                 CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_IMM,
        CL_BR,
        CL_LW,
        CL_SW,
        CL_J,
        CL_ILL
    } op_class_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_IMM0 = OP_W'(6'b000110);
    localparam logic [OP_W-1:0] OP_IMM1 = OP_W'(6'b000111);
    localparam logic [OP_W-1:0] OP_IMM2 = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_IMM3 = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_BR0  = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_BR1  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BR2  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        op_class_t c;
        if (op == OP_R)
            c = CL_R;
        else if (op == OP_IMM0 || op == OP_IMM1 || op == OP_IMM2 || op == OP_IMM3)
            c = CL_IMM;
        else if (op == OP_BR0 || op == OP_BR1 || op == OP_BR2)
            c = CL_BR;
        else if (op == OP_LW)
            c = CL_LW;
        else if (op == OP_SW)
            c = CL_SW;
        else if (op == OP_J)
            c = CL_J;
        else
            c = CL_ILL;
        return c;
    endfunction

    state_t           state_q;
    logic [OP_W-1:0]  op_q;
    logic [CNT_W-1:0] retired_q;
    op_class_t        cls;
    logic             retire;

    assign cls = classify(op_q);

    // An instruction completes on the edge that leaves its last state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            DECODE:  retire = (cls == CL_J);
            EXEC:    retire = (cls == CL_BR);
            MEM:     retire = (cls == CL_SW) && bus.mem_ready;
            WB:      retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.mem_ready) begin
                        state_q <= DECODE;
                        op_q    <= bus.instruction;
                    end
                end
                DECODE: begin
                    if (cls == CL_J || cls == CL_ILL)
                        state_q <= FETCH;
                    else
                        state_q <= EXEC;
                end
                EXEC: begin
                    case (cls)
                        CL_R, CL_IMM:  state_q <= WB;
                        CL_LW, CL_SW:  state_q <= MEM;
                        default:       state_q <= FETCH;
                    endcase
                end
                MEM: begin
                    if (bus.mem_ready)
                        state_q <= (cls == CL_LW) ? WB : FETCH;
                end
                WB:      state_q <= FETCH;
                // Encodings 5..7 recover to FETCH.
                default: state_q <= FETCH;
            endcase

            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Strobe decode. Gated by reset so that an asynchronous reset forces every
    // strobe low at once, even while the state register already reads FETCH.
    always_comb begin
        bus.pc_write = 1'b0;
        bus.ir_write = 1'b0;
        bus.RegDst   = 1'b0;
        bus.jump     = 1'b0;
        bus.Branch   = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUOP    = '0;
        bus.illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    bus.MemRead  = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                DECODE: begin
                    if (cls == CL_J) begin
                        bus.jump     = 1'b1;
                        bus.pc_write = 1'b1;
                    end
                    bus.illegal = (cls == CL_ILL);
                end
                EXEC: begin
                    case (cls)
                        CL_R: begin
                            bus.ALUOP = '1;
                        end
                        CL_IMM: begin
                            bus.ALUOP  = ALUOP_W'(op_q);
                            bus.ALUSrc = 1'b1;
                        end
                        CL_BR: begin
                            // PC update is gated in the datapath by Branch & zero.
                            bus.ALUOP  = ALUOP_W'(op_q);
                            bus.Branch = 1'b1;
                        end
                        CL_LW, CL_SW: begin
                            bus.ALUOP  = ALUOP_ADD;
                            bus.ALUSrc = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    bus.MemRead  = (cls == CL_LW);
                    bus.MemWrite = (cls == CL_SW);
                end
                WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = (cls == CL_IMM) || (cls == CL_LW);
                    bus.MemtoReg = (cls == CL_LW);
                end
                default: ;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule
